// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and operand-signedness helpers for alu_mc.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_OR     = 5'b00010,
    ALU_AND    = 5'b00011,
    ALU_SLTU   = 5'b00100,
    ALU_XOR    = 5'b00101,
    ALU_SGE    = 5'b00110,
    ALU_SLT    = 5'b00111,
    ALU_SGEU   = 5'b01000,
    ALU_SNE    = 5'b01001,
    ALU_SLL    = 5'b01010,
    ALU_SRL    = 5'b01011,
    ALU_SRA    = 5'b01100,
    ALU_SEQ    = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  // Most negative signed value at the default 32-bit width.
  localparam logic [31:0] MSB_MIN = 32'h8000_0000;

  // rs1 is treated as two's complement by these ops.
  function automatic logic is_signed_a(input alu_op_e op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  // rs2 is treated as two's complement by these ops.
  function automatic logic is_signed_b(input alu_op_e op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider on operand magnitudes,
// with the final sign correction and high/low or quotient/remainder select.
module muldiv_iter import alu_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         start,
  input  alu_op_e      op,
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] b_mag,
  input  logic         a_neg,
  input  logic         b_neg,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  cnt;
  logic [W-1:0]   hi, lo, opb;
  alu_op_e        op_q;
  logic           neg_q, rneg_q;
  logic           div_q;
  logic [W-1:0]   hi_n, lo_n;
  logic [W:0]     msum, shifted;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s;

  assign div_q = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  // One step: mul adds the multiplicand when the multiplier lsb is set and
  // shifts {hi,lo} right; div shifts a dividend bit into hi and subtracts
  // the divisor when it fits, shifting the quotient bit into lo.
  always_comb begin
    msum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[W-1]};
    hi_n    = msum[W:1];
    lo_n    = {msum[0], lo[W-1:1]};
    if (div_q) begin
      if (shifted >= {1'b0, opb}) begin
        hi_n = shifted[W-1:0] - opb;
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = shifted[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end
  end

  // Sign correction and selection applied to the final step's values.
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = rneg_q ? -hi_n : hi_n;
    case (op_q)
      ALU_MUL:                          result = prod_s[W-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod_s[2*W-1:W];
      ALU_DIV, ALU_DIVU:                result = quo_s;
      ALU_REM, ALU_REMU:                result = rem_s;
      default:                          result = '0;
    endcase
  end

  assign done = (cnt == CW'(1));

  // Load on start, then one step per cycle until the counter drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      op_q   <= ALU_ADD;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= CW'(W);
      hi     <= '0;
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      if (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
        lo  <= a_mag;
        opb <= b_mag;
      end else begin
        lo  <= b_mag;
        opb <= a_mag;
      end
    end else if (cnt != '0) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops, iterative RV32M mul/div, and the
// divide shortcuts, behind valid/ready handshakes with a registered result.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. out_valid and alu_result
// stay stable until the transfer. in_ready is high in IDLE, or in DONE when
// the current result is being taken, so ops stream back-to-back.
module alu_mc import alu_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    operand_a,
  input  logic [DATA_WIDTH-1:0]    operand_b,
  input  logic [OPCODE_LENGTH-1:0] alu_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     busy,
  output alu_state_e               dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  alu_state_e    state;
  alu_op_e       op;
  logic          accept, is_mul, is_div, div_zero, div_ovf, div_short, start;
  logic          a_neg, b_neg, md_done;
  logic [SW-1:0] shamt;
  logic [W-1:0]  base_res, fast_res, a_mag, b_mag, md_result;

  assign op        = alu_op_e'(alu_ctrl);
  assign shamt     = operand_b[SW-1:0];
  assign in_ready  = rst_n && ((state == IDLE) || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);
  assign dbg_state = state;

  assign is_mul    = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign is_div    = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign div_zero  = (operand_b == '0);
  assign div_ovf   = (op == ALU_DIV || op == ALU_REM) &&
                     (operand_a == SMIN) && (operand_b == '1);
  assign div_short = is_div && (div_zero || div_ovf);
  assign start     = accept && !flush && (is_mul || (is_div && !div_short));

  assign a_neg = is_signed_a(op) && operand_a[W-1];
  assign b_neg = is_signed_b(op) && operand_b[W-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  // Single-cycle ops; compares are zero-extended 0/1, unknown codes give 0.
  always_comb begin
    base_res = '0;
    case (op)
      ALU_ADD:  base_res = operand_a + operand_b;
      ALU_SUB:  base_res = operand_a - operand_b;
      ALU_OR:   base_res = operand_a | operand_b;
      ALU_AND:  base_res = operand_a & operand_b;
      ALU_XOR:  base_res = operand_a ^ operand_b;
      ALU_SLTU: base_res[0] = operand_a < operand_b;
      ALU_SGE:  base_res[0] = $signed(operand_a) >= $signed(operand_b);
      ALU_SLT:  base_res[0] = $signed(operand_a) < $signed(operand_b);
      ALU_SGEU: base_res[0] = operand_a >= operand_b;
      ALU_SNE:  base_res[0] = operand_a != operand_b;
      ALU_SEQ:  base_res[0] = operand_a == operand_b;
      ALU_SLL:  base_res = operand_a << shamt;
      ALU_SRL:  base_res = operand_a >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(operand_a) >>> shamt);
      default:  base_res = '0;
    endcase
  end

  // Result written at the accept edge: base op or a divide shortcut.
  always_comb begin
    fast_res = base_res;
    if (is_div) begin
      if (div_zero)
        fast_res = (op == ALU_DIV || op == ALU_DIVU) ? '1 : operand_a;
      else
        fast_res = (op == ALU_DIV) ? operand_a : '0;
    end
  end

  muldiv_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (flush),
    .start  (start),
    .op     (op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .a_neg  (a_neg),
    .b_neg  (b_neg),
    .done   (md_done),
    .result (md_result)
  );

  // Control FSM and output register; flush beats accept and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      if (is_mul) begin
        state <= MUL;
      end else if (is_div && !div_short) begin
        state <= DIV;
      end else begin
        state      <= DONE;
        alu_result <= fast_res;
      end
    end else begin
      case (state)
        MUL, DIV: begin
          if (md_done) begin
            state      <= DONE;
            alu_result <= md_result;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table through a scoreboard, plus
// hand-written busy, backpressure, flush and reset sequences.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  alu_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        busy;
  alu_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV     = 34;
  localparam int N_BASE = 16;
  vec_t vecs [NV];

  alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one op (called just after a rising edge); record the expectation
  // on the cycle it is taken, then scramble the inputs after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, output int waited);
    waited    = 0;
    in_valid  = 1'b1;
    alu_ctrl  = op;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, want 1");
    end else begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    alu_ctrl  = 5'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, want 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each result as it is taken by the consumer.
  logic [31:0] m_exp;
  int          m_lat, m_acc;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%08h, want no result", alu_result);
      end else begin
        m_exp = exp_q.pop_front();
        m_lat = lat_q.pop_front();
        m_acc = acc_q.pop_front();
        chk("result", alu_result, m_exp);
        if (m_lat != 0) chk("latency", 32'(cyc - m_acc), 32'(m_lat));
      end
    end
  end

  initial begin
    int w, ok;
    logic [31:0] ra, rb, held;
    logic [63:0] p;

    vecs[0]  = '{ALU_ADD,    32'd7,         32'd5,         32'd12,        1};
    vecs[1]  = '{ALU_SUB,    32'd3,         32'd5,         32'hFFFFFFFE,  1};
    vecs[2]  = '{ALU_SLT,    32'hFFFFFFFF,  32'd1,         32'd1,         1};
    vecs[3]  = '{ALU_SLTU,   32'hFFFFFFFF,  32'd1,         32'd0,         1};
    vecs[4]  = '{ALU_SRA,    32'h80000000,  32'd4,         32'hF8000000,  1};
    vecs[5]  = '{ALU_OR,     32'hF0,        32'h0F,        32'hFF,        1};
    vecs[6]  = '{ALU_AND,    32'hFF,        32'h3C,        32'h3C,        1};
    vecs[7]  = '{ALU_XOR,    32'hAA,        32'hFF,        32'h55,        1};
    vecs[8]  = '{ALU_SGE,    32'hFFFFFFFE,  32'd3,         32'd0,         1};
    vecs[9]  = '{ALU_SGEU,   32'hFFFFFFFE,  32'd3,         32'd1,         1};
    vecs[10] = '{ALU_SNE,    32'd5,         32'd5,         32'd0,         1};
    vecs[11] = '{ALU_SEQ,    32'd5,         32'd5,         32'd1,         1};
    vecs[12] = '{ALU_SLL,    32'd1,         32'd35,        32'd8,         1};
    vecs[13] = '{ALU_SRL,    32'h80000000,  32'd31,        32'd1,         1};
    vecs[14] = '{5'b01110,   32'd9,         32'd9,         32'd0,         1};
    vecs[15] = '{5'b11000,   32'd9,         32'd9,         32'd0,         1};
    vecs[16] = '{ALU_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  33};
    vecs[17] = '{ALU_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  33};
    vecs[18] = '{ALU_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33};
    vecs[19] = '{ALU_MULHSU, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  33};
    vecs[20] = '{ALU_DIV,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33};
    vecs[21] = '{ALU_REM,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33};
    vecs[22] = '{ALU_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[23] = '{ALU_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[24] = '{ALU_DIV,    32'd5,         32'd0,         32'hFFFFFFFF,  1};
    vecs[25] = '{ALU_REM,    32'd5,         32'd0,         32'd5,         1};
    vecs[26] = '{ALU_DIVU,   32'd5,         32'd0,         32'hFFFFFFFF,  1};
    vecs[27] = '{ALU_REMU,   32'd5,         32'd0,         32'd5,         1};
    vecs[28] = '{ALU_DIV,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
    vecs[29] = '{ALU_REM,    32'h80000000,  32'hFFFFFFFF,  32'd0,         1};
    vecs[30] = '{ALU_DIVU,   32'h80000000,  32'hFFFFFFFF,  32'd0,         33};
    vecs[31] = '{ALU_REMU,   32'h80000000,  32'hFFFFFFFF,  32'h80000000,  33};
    vecs[32] = '{ALU_REM,    32'd7,         32'hFFFFFFFE,  32'd1,         33};
    vecs[33] = '{ALU_DIV,    32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33};

    // Reset state
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", alu_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table: base ops stream with in_ready held high, then M ops / corners
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, w);
      if (i < N_BASE) chk("stream_ready_wait", 32'(w), 32'd0);
      if (i == N_BASE) begin
        ok = 0;
        for (int k = 1; k <= 32; k++) begin
          @(negedge clk);
          if (busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0) ok++;
        end
        chk("mul_busy_cycles", 32'(ok), 32'd32);
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Random mul / divu against the bench's own arithmetic
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      p  = 64'(ra) * 64'(rb);
      if (i % 2 == 0) issue(ALU_MUL, ra, rb, p[31:0], 33, w);
      else            issue(ALU_DIVU, ra, rb, ra / rb, 33, w);
    end
    drain();

    // Backpressure: result held, new offers refused, then same-cycle take
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd40, 32'd2, 32'd42, 0, w);
    in_valid  = 1'b1;
    alu_ctrl  = ALU_SUB;
    ok = 0;
    held = 32'd42;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && alu_result === held && in_ready === 1'b0) ok++;
    end
    chk("backpressure_hold", 32'(ok), 32'd5);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(ALU_XOR, 32'h0F0F, 32'h00FF, 32'h0FF0, 1, w);
    chk("backpressure_same_cycle_accept", 32'(w), 32'd0);
    drain();

    // Flush during a divu: back to idle, no result ever presented
    in_valid  = 1'b1;
    alu_ctrl  = ALU_DIVU;
    operand_a = 32'd100;
    operand_b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("flush_pre_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b0) ok++;
    end
    chk("flush_no_valid", 32'(ok), 32'd40);
    // Flush with a same-cycle accept discards the op
    @(posedge clk);
    #1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = ALU_ADD;
    operand_a = 32'd1;
    operand_b = 32'd1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_discard", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a mul
    issue(ALU_ADD, 32'h1234, 32'h1, 32'h1235, 1, w);
    drain();
    in_valid  = 1'b1;
    alu_ctrl  = ALU_MUL;
    operand_a = 32'd3;
    operand_b = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_result", alu_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    chk("rst_release_valid", 32'(out_valid), 32'd0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b0 && busy === 1'b0) ok++;
    end
    chk("rst_no_partial_result", 32'(ok), 32'd20);
    @(posedge clk);
    #1;
    issue(ALU_SUB, 32'd10, 32'd4, 32'd6, 1, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
